md_issue_ctrl: RTL

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_issue_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue control for the multiply/divide unit.
// Holds back decode while a mult/div result is pending. A shadow countdown
// mirrors the unit latency, so HI/LO reads can never see a stale value.
// Also drives the unit's start/op/operand inputs and counts completed issues.
//
// state | meaning
// IDLE  | no mult/div in flight; requests are accepted once cnt and md_busy are clear
// START | unit start cycle; an exception here cancels the operation
// EXEC  | operation running; cnt counts down the shadow latency
module md_issue_ctrl #(
    parameter int          MUL_LAT   = 5,
    parameter int          DIV_LAT   = 10,
    parameter logic [15:0] PERF_INIT = 16'h0000   // reset value of n_mul/n_div
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        exc_req,
    input  logic        md_busy,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_req,
    output logic        stall,
    output logic        issue_ack,
    output logic        rd_en,
    output logic        rd_hi,
    output logic [15:0] n_mul,
    output logic [15:0] n_div
);

    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT + 1);
    localparam logic [4:0] DIV_CNT = 5'(DIV_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] cnt;
    logic [4:0] cnt_nxt;
    logic [4:0] cnt_dec;
    logic       op_ok;
    logic       op_md;
    logic       op_mul;
    logic       op_wr;
    logic       busy_int;
    logic       start_mul;

    // Request decode, hazard detection and HI/LO read select.
    always_comb begin
        op_ok     = (req_op >= 4'd1) && (req_op <= 4'd8);
        op_md     = (req_op == 4'd1) || (req_op == 4'd2) ||
                    (req_op == 4'd7) || (req_op == 4'd8);
        op_mul    = (req_op == 4'd1) || (req_op == 4'd7);
        op_wr     = (req_op == 4'd3) || (req_op == 4'd4);
        busy_int  = (cnt != 5'd0) || md_busy || (state == START);
        stall     = req_valid && op_ok && busy_int;
        issue_ack = req_valid && op_ok && !busy_int;
        rd_en     = issue_ack && ((req_op == 4'd5) || (req_op == 4'd6));
        rd_hi     = issue_ack && (req_op == 4'd5);
        md_req    = exc_req;
        cnt_dec   = (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
        // md_op still holds the accepted op while in START
        start_mul = (md_op == 4'd1) || (md_op == 4'd7);
    end

    // Next state and shadow countdown; a new mult/div issue overrides the
    // EXEC->IDLE exit in the cycle the countdown has drained.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            START: begin
                if (exc_req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 5'd0;
                end else begin
                    state_nxt = EXEC;
                    cnt_nxt   = cnt_dec;
                end
            end
            EXEC: begin
                cnt_nxt = cnt_dec;
                if ((cnt == 5'd0) && !md_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 5'd0;
            end
        endcase
        if (issue_ack && op_md) begin
            state_nxt = START;
            cnt_nxt   = op_mul ? MUL_CNT : DIV_CNT;
        end
    end

    // State and countdown registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered unit inputs: start/op are single-cycle, operands hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_start <= 1'b0;
            md_op    <= 4'd0;
            md_a     <= 32'd0;
            md_b     <= 32'd0;
        end else begin
            md_start <= 1'b0;
            md_op    <= 4'd0;
            if (issue_ack && op_md) begin
                md_start <= 1'b1;
                md_op    <= req_op;
                md_a     <= req_a;
                md_b     <= req_b;
            end else if (issue_ack && op_wr) begin
                md_op <= req_op;
                md_a  <= req_a;
            end
        end
    end

    // Completed-issue counters, bumped when START survives without a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_mul <= PERF_INIT;
            n_div <= PERF_INIT;
        end else if ((state == START) && !exc_req) begin
            if (start_mul) begin
                n_mul <= n_mul + 16'd1;
            end else begin
                n_div <= n_div + 16'd1;
            end
        end
    end

endmodule
